// File: rtl/window_pkg.sv
// Shared types and widths for the window stream sequencer.
// Optional feature macro: WSS_TIMEOUT_EN (idle timeout abort).
package window_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_FLUSH,
      S_DONE
   } wss_state_t;

   // Counter widths for the default 420x240 frame with 2 pad rows.
   localparam int WSS_X_W = 9;
   localparam int WSS_Y_W = 8;

   // Bit width able to index n positions (never below one bit).
   function automatic int wss_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wss_xy_counter.sv
// Raster x/y position counter with wrap, restart, clear and
// a load that jumps straight to the first blanking row.
module wss_xy_counter
   import window_pkg::*;
#(
   parameter int WIDTH  = 420,
   parameter int YN     = 242,
   parameter int Y_LOAD = 240,
   parameter int XW     = WSS_X_W,
   parameter int YW     = WSS_Y_W
)(
   input  logic          clock,
   input  logic          reset,
   input  logic          i_clr,
   input  logic          i_restart,
   input  logic          i_load,
   input  logic          i_inc,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y
);

   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(YN - 1);

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [XW-1:0] w_bx;
   logic [YW-1:0] w_by;

   // A restarting beat counts from the origin, not the old position.
   assign w_bx = i_restart ? '0 : r_x;
   assign w_by = i_restart ? '0 : r_y;

   // Position register: clear, load, or advance one beat.
   always_ff @(posedge clock) begin
      if (reset || i_clr) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_load) begin
         r_x <= '0;
         r_y <= YW'(Y_LOAD);
      end else if (i_inc) begin
         if (w_bx == X_LAST) begin
            r_x <= '0;
            r_y <= (w_by == Y_LAST) ? '0 : w_by + YW'(1);
         end else begin
            r_x <= w_bx + XW'(1);
            r_y <= w_by;
         end
      end
   end

   assign o_x = r_x;
   assign o_y = r_y;

endmodule

// File: rtl/window_stream_sequencer.sv
// Sequences an upstream pixel stream into a 5x5 window datapath and
// appends blanking rows per frame. Optional macro: WSS_TIMEOUT_EN.
module window_stream_sequencer
   import window_pkg::*;
#(
   parameter int WIDTH    = 420,
   parameter int HEIGHT   = 240,
   parameter int PAD_ROWS = 2,
   parameter int TIMEOUT  = 4096
)(
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              s_valid,
   input  logic [7:0]                        s_data,
   input  logic                              s_sof,
   output logic                              s_ready,
   output logic [7:0]                        win_din,
   output logic                              win_valid,
   output logic                              win_blanking,
   output logic [wss_w(WIDTH)-1:0]           x_pos,
   output logic [wss_w(HEIGHT+PAD_ROWS)-1:0] y_pos,
   output logic                              busy,
   output logic                              frame_done,
   output logic                              sof_err,
   output logic                              abort
);

   localparam int XW = wss_w(WIDTH);
   localparam int YN = HEIGHT + PAD_ROWS;
   localparam int YW = wss_w(YN);

   localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_A_LST = YW'(HEIGHT - 1);
   localparam logic [YW-1:0] Y_F_LST = YW'(YN - 1);

   wss_state_t    r_state;
   wss_state_t    w_next;
   logic          w_inc;
   logic          w_restart;
   logic          w_load;
   logic          w_clr;
   logic          w_timeout;
   logic          w_last_act;
   logic          w_last_fl;
   logic [XW-1:0] w_rx;
   logic [YW-1:0] w_ry;
   logic [XW-1:0] w_px;
   logic [YW-1:0] w_py;

   wss_xy_counter #(
      .WIDTH  (WIDTH),
      .YN     (YN),
      .Y_LOAD (HEIGHT),
      .XW     (XW),
      .YW     (YW)
   ) u_xy (
      .clock     (clock),
      .reset     (reset),
      .i_clr     (w_clr),
      .i_restart (w_restart),
      .i_load    (w_load),
      .i_inc     (w_inc),
      .o_x       (w_rx),
      .o_y       (w_ry)
   );

   // Any accepted start-of-frame pixel re-anchors the raster at 0,0.
   assign w_restart = s_valid && s_sof &&
                      ((r_state == S_IDLE) || (r_state == S_ACTIVE));

   assign w_px       = w_restart ? '0 : w_rx;
   assign w_py       = w_restart ? '0 : w_ry;
   assign w_last_act = (w_px == X_LAST) && (w_py == Y_A_LST);
   assign w_last_fl  = (w_px == X_LAST) && (w_py == Y_F_LST);

   assign x_pos      = w_px;
   assign y_pos      = w_py;
   assign busy       = (r_state == S_ACTIVE) || (r_state == S_FLUSH);
   assign frame_done = (r_state == S_DONE);

`ifdef WSS_TIMEOUT_EN
   localparam int TW = wss_w(TIMEOUT + 1);

   logic [TW-1:0] r_idle;

   // Count consecutive ACTIVE cycles with no accepted pixel.
   always_ff @(posedge clock) begin
      if (reset || (r_state != S_ACTIVE) || s_valid)
         r_idle <= '0;
      else
         r_idle <= r_idle + TW'(1);
   end

   assign w_timeout = (r_idle == TW'(TIMEOUT - 1));
`else
   // No idle watchdog: ACTIVE waits for pixels indefinitely.
   assign w_timeout = (TIMEOUT < 0);
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next state, handshake and window feed decode.
   always_comb begin
      w_next       = r_state;
      s_ready      = 1'b0;
      win_valid    = 1'b0;
      win_din      = '0;
      win_blanking = 1'b0;
      sof_err      = 1'b0;
      abort        = 1'b0;
      w_inc        = 1'b0;
      w_load       = 1'b0;
      w_clr        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            s_ready = 1'b1;
            if (w_restart) begin
               win_valid = 1'b1;
               win_din   = s_data;
               w_inc     = 1'b1;
               w_next    = w_last_act ? S_FLUSH : S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               win_valid = 1'b1;
               win_din   = s_data;
               w_inc     = 1'b1;
               sof_err   = s_sof && ((w_rx != '0) || (w_ry != '0));
               if (w_last_act)
                  w_next = S_FLUSH;
            end else if (w_timeout) begin
               abort  = 1'b1;
               w_load = 1'b1;
               w_next = S_FLUSH;
            end
         end
         S_FLUSH: begin
            win_valid    = 1'b1;
            win_blanking = 1'b1;
            w_inc        = 1'b1;
            if (w_last_fl)
               w_next = S_DONE;
         end
         S_DONE: begin
            w_clr  = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_window_stream_sequencer.sv
// Bench for window_stream_sequencer: frame-level reference model
// compared every cycle, directed scenarios plus random traffic.
`timescale 1ns/1ps
module tb_window_stream_sequencer;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int P  = 2;
   localparam int TO = 16;

   logic       clock   = 1'b0;
   logic       reset   = 1'b1;
   logic       s_valid = 1'b0;
   logic       s_sof   = 1'b0;
   logic [7:0] s_data  = 8'h00;
   logic       s_ready;
   logic [7:0] win_din;
   logic       win_valid;
   logic       win_blanking;
   logic [2:0] x_pos;
   logic [2:0] y_pos;
   logic       busy;
   logic       frame_done;
   logic       sof_err;
   logic       abort;

   window_stream_sequencer #(
      .WIDTH    (W),
      .HEIGHT   (H),
      .PAD_ROWS (P),
      .TIMEOUT  (TO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_sof        (s_sof),
      .s_ready      (s_ready),
      .win_din      (win_din),
      .win_valid    (win_valid),
      .win_blanking (win_blanking),
      .x_pos        (x_pos),
      .y_pos        (y_pos),
      .busy         (busy),
      .frame_done   (frame_done),
      .sof_err      (sof_err),
      .abort        (abort)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model: 0 idle, 1 in frame, 2 draining pad rows, 3 frame done.
   int m_mode = 0;
   int m_pix  = 0;
   int m_fl   = 0;
   int m_idle = 0;

   int st_pass, st_blank, st_fd, st_se, st_ab, st_frm;
   int se_x, se_y, last_x, last_y;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic clr_stats();
      st_pass = 0; st_blank = 0; st_fd = 0;
      st_se = 0; st_ab = 0; st_frm = 0;
      se_x = -1; se_y = -1; last_x = -1; last_y = -1;
   endtask

   task automatic step(input logic v, input logic sof,
                       input logic [7:0] d, input logic rst);
      s_valid = v;
      s_sof   = sof;
      s_data  = d;
      reset   = rst;
      @(posedge clock);
      #1;
   endtask

   task automatic pix(input logic sof);
      step(1'b1, sof, 8'($urandom), 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   // Reference compare on the falling edge, then advance the model.
   always @(negedge clock) begin
      logic e_v, e_b, e_se, e_ab, e_fd, e_busy, e_rdy, ck_rdy, ck_xy;
      logic [7:0] e_d;
      int e_x, e_y, n_mode, n_pix, n_fl, n_idle;
      if (chk_en) begin
         e_v = 0; e_b = 0; e_se = 0; e_ab = 0; e_fd = 0;
         e_busy = 0; e_rdy = 0; ck_rdy = 1; ck_xy = 1;
         e_d = 8'h00; e_x = 0; e_y = 0;
         n_mode = m_mode; n_pix = m_pix; n_fl = m_fl; n_idle = m_idle;
         case (m_mode)
            0: begin
               e_rdy = 1;
               if (s_valid && s_sof) begin
                  e_v = 1; e_d = s_data;
                  n_pix = 1; n_idle = 0; n_fl = 0;
                  n_mode = (W * H == 1) ? 2 : 1;
               end
            end
            1: begin
               e_rdy = 1; e_busy = 1;
               e_x = m_pix % W; e_y = m_pix / W;
               if (s_valid) begin
                  e_v = 1; e_d = s_data; n_idle = 0;
                  if (s_sof) begin
                     e_se = 1; e_x = 0; e_y = 0; n_pix = 1;
                  end else begin
                     n_pix = m_pix + 1;
                  end
                  if (n_pix == W * H) begin
                     n_mode = 2; n_fl = 0;
                  end
               end else begin
                  n_idle = m_idle + 1;
`ifdef WSS_TIMEOUT_EN
                  if (n_idle == TO) begin
                     e_ab = 1; n_mode = 2; n_fl = 0;
                  end
`endif
               end
            end
            2: begin
               e_busy = 1; e_v = 1; e_b = 1;
               e_x = m_fl % W; e_y = H + m_fl / W;
               n_fl = m_fl + 1;
               if (n_fl == P * W) n_mode = 3;
            end
            default: begin
               e_fd = 1; ck_rdy = 0; ck_xy = 0;
               n_mode = 0; n_pix = 0;
            end
         endcase
         if (ck_rdy) chk("s_ready", s_ready, e_rdy);
         chk("win_valid", win_valid, e_v);
         chk("win_din", win_din, e_d);
         chk("win_blanking", win_blanking, e_b);
         chk("busy", busy, e_busy);
         chk("frame_done", frame_done, e_fd);
         chk("sof_err", sof_err, e_se);
         chk("abort", abort, e_ab);
         if (ck_xy) begin
            chk("x_pos", x_pos, e_x);
            chk("y_pos", y_pos, e_y);
         end
         if (win_valid && !win_blanking) begin
            st_pass++; last_x = x_pos; last_y = y_pos;
         end
         if (win_valid && win_blanking) st_blank++;
         if (frame_done) st_fd++;
         if (sof_err) begin
            st_se++; se_x = x_pos; se_y = y_pos;
         end
         if (abort) st_ab++;
         if (win_valid || frame_done) st_frm++;
         if (reset) begin
            m_mode = 0; m_pix = 0; m_fl = 0; m_idle = 0;
         end else begin
            m_mode = n_mode; m_pix = n_pix; m_fl = n_fl; m_idle = n_idle;
         end
      end
   end

   initial begin
      clr_stats();
      repeat (2) @(posedge clock);
      #1;
      chk_en = 1'b1;
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", win_valid, 0);
      chk("rst_xy", {x_pos, y_pos}, 0);

      // Pixels without start-of-frame are dropped in idle.
      clr_stats();
      repeat (4) pix(1'b0);
      chk("idle_ready", s_ready, 1);
      chk("idle_valid", win_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_beats", st_frm, 0);

      // Continuous frame.
      clr_stats();
      pix(1'b1);
      repeat (W * H - 1) pix(1'b0);
      idle(18);
      chk("cont_pass", st_pass, 32);
      chk("cont_blank", st_blank, 16);
      chk("cont_fd", st_fd, 1);
      chk("cont_cycles", st_frm, 49);
      chk("cont_last_xy", {last_x[2:0], last_y[2:0]}, {3'd7, 3'd3});

      // Gapped input: every other cycle.
      clr_stats();
      pix(1'b1);
      repeat (W * H - 1) begin
         idle(1);
         pix(1'b0);
      end
      idle(18);
      chk("gap_pass", st_pass, 32);
      chk("gap_blank", st_blank, 16);
      chk("gap_fd", st_fd, 1);
      chk("gap_last_xy", {last_x[2:0], last_y[2:0]}, {3'd7, 3'd3});

      // Early start-of-frame at pixel 13.
      clr_stats();
      pix(1'b1);
      repeat (12) pix(1'b0);
      pix(1'b1);
      repeat (W * H - 1) pix(1'b0);
      idle(18);
      chk("early_sof_err", st_se, 1);
      chk("early_sof_xy", {se_x[2:0], se_y[2:0]}, 0);
      chk("early_pass", st_pass, 45);
      chk("early_fd", st_fd, 1);

      // Reset at flush beat 5.
      clr_stats();
      pix(1'b1);
      repeat (W * H - 1) pix(1'b0);
      idle(5);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk("rstfl_valid", win_valid, 0);
      chk("rstfl_busy", busy, 0);
      idle(20);
      chk("rstfl_blank", st_blank, 6);
      chk("rstfl_fd", st_fd, 0);

      // Reset mid-frame.
      clr_stats();
      pix(1'b1);
      repeat (9) pix(1'b0);
      step(1'b1, 1'b0, 8'h11, 1'b1);
      chk("rstmid_busy", busy, 0);
      idle(20);
      chk("rstmid_blank", st_blank, 0);

      // Input stall at pixel 10.
      clr_stats();
      pix(1'b1);
      repeat (9) pix(1'b0);
      idle(TO);
`ifdef WSS_TIMEOUT_EN
      chk("to_abort", st_ab, 1);
      idle(18);
      chk("to_blank", st_blank, 16);
      chk("to_fd", st_fd, 1);
`else
      idle(TO);
      chk("to_abort", st_ab, 0);
      chk("to_busy", busy, 1);
      chk("to_blank", st_blank, 0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
`endif

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         logic v, sof, rst;
         v = ($urandom_range(0, 9) < 7);
         if (m_mode == 0) sof = ($urandom_range(0, 2) == 0);
         else sof = ($urandom_range(0, 99) == 0);
         rst = ($urandom_range(0, 499) == 0);
         step(v, sof, 8'($urandom), rst);
      end
      idle(60);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
